// File: rtl/axo_uart_pkg.sv
// axo_uart_pkg: register map, STATUS bit positions and serialiser states for axo_mem_uart_tx.
package axo_uart_pkg;
  localparam logic [3:0] REG_TXDATA  = 4'h0;
  localparam logic [3:0] REG_STATUS  = 4'h4;
  localparam logic [3:0] REG_DIVISOR = 4'h8;
  localparam logic [3:0] REG_CTRL    = 4'hC;
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_COUNT = 8;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_e;
endpackage

// File: rtl/axo_sync_fifo.sv
// axo_sync_fifo: show-ahead synchronous FIFO; push ignored when full, pop ignored when empty.
module axo_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/axo_mem_uart_tx.sv
// axo_mem_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO and programmable baud divisor.
// Define AXO_UART_PARITY_EN to add the CTRL register and an optional parity bit.
module axo_mem_uart_tx
  import axo_uart_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [1:0]  mem_asize,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic        mem_error,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        irq
);
  localparam int CW = $clog2(DEPTH) + 1;
  uart_state_e state, state_d;
  logic [15:0] div, cnt;
  logic [2:0] idx;
  logic [7:0] data, fifo_rdata;
  logic [CW-1:0] count;
  logic [31:0] status;
  logic [3:0] reg_off;
  logic [1:0] ctrl_rd;
  logic full, empty, pop, push, tick, busy, req, err, is_tx, wr_ok, rd_ok, par_en, par_bit;
  logic unused;
  assign unused = ^{mem_addr[31:4], mem_wdata[31:16]};
  assign reg_off = {mem_addr[3:2], 2'b00};
  assign is_tx = reg_off == REG_TXDATA;
  assign req = mem_re | mem_we;
  // Only TXDATA accepts sub-word accesses; every fault completes immediately.
  assign err = (mem_re & mem_we) | (mem_asize == 2'd3) | (mem_asize == 2'd1 & mem_addr[0])
             | (mem_asize == 2'd2 & |mem_addr[1:0]) | (mem_asize != 2'd2 & !is_tx);
  assign wr_ok = mem_we & !err;
  assign rd_ok = mem_re & !err;
  assign push = wr_ok & is_tx & !full;
  assign mem_ready = req & !(wr_ok & is_tx & full);
  assign mem_error = req & err;
  assign busy = state != S_IDLE;
  assign irq = empty & !busy;
  assign tick = cnt == '0;
  always_comb begin
    status = '0;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY] = busy;
    status[ST_COUNT +: 8] = 8'(count);
  end
  assign mem_rdata = !rd_ok ? '0 : reg_off == REG_STATUS ? status
                   : reg_off == REG_DIVISOR ? {16'b0, div}
                   : reg_off == REG_CTRL ? {30'b0, ctrl_rd} : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div <= DEFAULT_DIV;
    else if (wr_ok && reg_off == REG_DIVISOR) div <= mem_wdata[15:0];
`ifdef AXO_UART_PARITY_EN
  logic [1:0] ctrl;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ctrl <= '0;
    else if (wr_ok && reg_off == REG_CTRL) ctrl <= mem_wdata[1:0];
  assign ctrl_rd = ctrl;
  assign par_en = ctrl[0];
  assign par_bit = ^data ^ ctrl[1];
`else
  assign ctrl_rd = 2'b00;
  assign par_en = 1'b0;
  assign par_bit = 1'b0;
`endif
  axo_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .wdata(mem_wdata[7:0]), .pop(pop),
    .rdata(fifo_rdata), .full(full), .empty(empty), .count(count)
  );
  always_comb begin
    state_d = state;
    pop = 1'b0;
    tx = 1'b1;
    case (state)
      S_IDLE: if (!empty) begin
        state_d = S_START;
        pop = 1'b1;
      end
      S_START: begin
        tx = 1'b0;
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        tx = data[idx];
        if (tick && idx == 3'd7) state_d = par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        tx = par_bit;
        if (tick) state_d = S_STOP;
      end
      S_STOP: if (tick) begin
        state_d = empty ? S_IDLE : S_START;
        pop = !empty;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // The baud counter follows DIVISOR while idle and reloads at each bit boundary.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      idx <= '0;
      data <= '0;
    end else begin
      state <= state_d;
      cnt <= (state == S_IDLE || tick) ? div : cnt - 1'b1;
      idx <= state != S_DATA ? '0 : tick ? idx + 1'b1 : idx;
      if (pop) data <= fifo_rdata;
    end
endmodule

// File: tb/tb_axo_mem_uart_tx.sv
// tb_axo_mem_uart_tx: scoreboard bench; bus responses and serial frames are checked by separate monitors.
module tb_axo_mem_uart_tx;
  logic clk = 0, rst_n = 0, mem_re = 0, mem_we = 0;
  logic [1:0] mem_asize = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0;
  logic mem_ready, mem_error, tx, irq;
  logic [31:0] mem_rdata;
  always #5 clk = ~clk;
  axo_mem_uart_tx #(.DEPTH(4), .DEFAULT_DIV(16'd433)) dut (
    .clk(clk), .rst_n(rst_n), .mem_re(mem_re), .mem_we(mem_we), .mem_asize(mem_asize),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_error(mem_error),
    .mem_rdata(mem_rdata), .tx(tx), .irq(irq)
  );
  int total = 0, bad = 0;
  typedef struct {logic err; logic chk; logic [31:0] rdata;} rsp_t;
  typedef struct {int n; logic [11:0] bits;} frame_t;
  rsp_t rsp_q[$];
  frame_t frm_q[$];
  int bc = 434;
  logic par_en = 0, par_odd = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  rsp_t r;
  always @(negedge clk)
    if (mem_ready) begin
      if (rsp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got ready=1 expected no response");
      end else begin
        r = rsp_q.pop_front();
        chk("bus_error", 32'(mem_error), 32'(r.err));
        if (r.chk) chk("bus_rdata", mem_rdata, r.rdata);
      end
    end
  frame_t f;
  logic ok, aborted;
  logic [11:0] got;
  always begin
    @(negedge clk);
    if (rst_n && !tx) begin
      if (frm_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame: got start bit expected idle line");
      end else begin
        f = frm_q.pop_front();
        ok = 1;
        aborted = 0;
        got = '0;
        for (int b = 0; b < f.n; b++)
          for (int c = 0; c < bc; c++)
            if (!aborted && (b != 0 || c != 0)) begin
              @(negedge clk);
              if (!rst_n) aborted = 1;
              else begin
                if (tx !== f.bits[b]) ok = 0;
                if (c == 0) got[b] = tx;
              end
            end
        if (!aborted) chk("tx_frame", {19'b0, ok, got}, {19'b0, 1'b1, f.bits});
      end
    end
  end
  task automatic bus(input logic re, input logic we, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] d, input logic err, input logic chkd, input logic [31:0] exp,
                     output int lat);
    rsp_q.push_back('{err, chkd, exp});
    mem_re = re;
    mem_we = we;
    mem_asize = sz;
    mem_addr = a;
    mem_wdata = d;
    lat = 0;
    @(negedge clk);
    while (!mem_ready && lat < 200) begin
      lat++;
      @(negedge clk);
    end
    if (!mem_ready) begin
      total++;
      bad++;
      $display("FAIL bus_timeout: got no ready expected ready at addr %h", a);
      void'(rsp_q.pop_back());
    end
    @(posedge clk);
    #1;
    mem_re = 0;
    mem_we = 0;
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    int lat;
    bus(1, 0, 2'd2, a, 0, 0, 1, exp, lat);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    int lat;
    bus(0, 1, 2'd2, a, d, 0, 0, 0, lat);
  endtask
  task automatic bad_acc(input logic re, input logic we, input logic [1:0] sz, input logic [31:0] a);
    int lat;
    bus(re, we, sz, a, 32'hFFFF_FFFF, 1, 0, 0, lat);
  endtask
  task automatic send(input logic [7:0] b, input int exp_lat);
    int lat;
    frm_q.push_back(par_en ? '{11, {1'b1, ^b ^ par_odd, b, 1'b0}} : '{10, {2'b00, 1'b1, b, 1'b0}});
    bus(0, 1, 2'd0, 0, {24'b0, b}, 0, 0, 0, lat);
    chk("send_latency", 32'(lat), 32'(exp_lat));
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (!irq && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("irq_idle", 32'(irq), 1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 1);
    chk("rst_irq", 32'(irq), 1);
    chk("rst_ready", 32'(mem_ready), 0);
    chk("rst_error", 32'(mem_error), 0);
    chk("rst_rdata", mem_rdata, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    rd(32'h8, 32'd433);
    rd(32'h4, 32'h2);
    wr(32'h8, 32'd3);
    bc = 4;
    rd(32'h8, 32'd3);
    send(8'h55, 0);
    chk("busy_irq", 32'(irq), 0);
    wait_idle(n);
    chk("frame_len_55", 32'(n), 41);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    rd(32'h4, 32'h0000_0204);
    wait_idle(n);
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'h80, 0);
    send(8'hFF, 0);
    send(8'h3C, 0);
    send(8'hA5, 37);
    wait_idle(n);
    bad_acc(1, 0, 2'd2, 32'h6);
    bad_acc(0, 1, 2'd1, 32'h4);
    bad_acc(1, 0, 2'd0, 32'h8);
    bad_acc(1, 1, 2'd2, 32'h0);
    bad_acc(0, 1, 2'd3, 32'h0);
    bad_acc(0, 1, 2'd1, 32'h8);
    rd(32'h8, 32'd3);
    rd(32'h4, 32'h2);
    wr(32'hC, 32'd3);
`ifdef AXO_UART_PARITY_EN
    rd(32'hC, 32'd3);
    par_en = 1;
    par_odd = 1;
    send(8'h07, 0);
    wait_idle(n);
    chk("frame_len_par", 32'(n), 45);
    wr(32'hC, 32'd0);
    par_en = 0;
    par_odd = 0;
`else
    rd(32'hC, 32'd0);
    send(8'h07, 0);
    wait_idle(n);
    chk("frame_len_07", 32'(n), 41);
`endif
    send(8'h55, 0);
    repeat (18) @(posedge clk);
    #1;
    chk("tx_data_bit3", 32'(tx), 0);
    rst_n = 0;
    #1;
    chk("rst_mid_tx", 32'(tx), 1);
    chk("rst_mid_irq", 32'(irq), 1);
    repeat (2) @(posedge clk);
    #1;
    frm_q.delete();
    rst_n = 1;
    bc = 434;
    @(posedge clk);
    #1;
    rd(32'h4, 32'h2);
    rd(32'h8, 32'd433);
    repeat (5) @(posedge clk);
    #1;
    chk("frames_left", 32'(frm_q.size()), 0);
    chk("rsps_left", 32'(rsp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
